// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between requesters A..D.
// Ports: clk, reset (sync, active-high), req[3:0], data_a..data_d in;
//   grant[3:0], S0/S1 select, out_data, out_valid, busy out.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_c,
    input  logic [DATA_W-1:0] data_d,
    output logic [3:0]        grant,
    output logic              S0,
    output logic              S1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] sel;
    logic [1:0] last;
    logic [7:0] cnt;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       rel;

    // Scan upward from the slot after the last grantee; the last
    // grantee is naturally checked last, so it wins only when alone.
    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign rel = !req[sel] || (cnt == 8'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            cnt   <= 8'd0;
            last  <= 2'd3;
        end else if (state == IDLE || rel) begin
            if (found) begin
                state <= GRANT;
                sel   <= win;
                grant <= 4'b0001 << win;
                cnt   <= 8'd1;
                last  <= win;
            end else begin
                // Nobody asking: drop to idle, sel keeps its value.
                state <= IDLE;
                grant <= 4'b0000;
                cnt   <= 8'd0;
            end
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign busy = (state == GRANT);
    assign S0   = sel[0];
    assign S1   = sel[1];

    // Beat is valid only while the grantee still asserts its request.
    assign out_valid = busy && req[sel];

    always_comb begin
        out_data = data_a;
        unique case (sel)
            2'd0: out_data = data_a;
            2'd1: out_data = data_b;
            2'd2: out_data = data_c;
            2'd3: out_data = data_d;
            default: out_data = data_a;
        endcase
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic
// checked each cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] da, db, dc, dd;

    logic [3:0] g  [2];
    logic       s0 [2];
    logic       s1 [2];
    logic [7:0] od [2];
    logic       ov [2];
    logic       bz [2];

    int errs   = 0;
    int checks = 0;
    bit checking = 0;

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .reset(reset), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .grant(g[0]), .S0(s0[0]), .S1(s1[0]),
        .out_data(od[0]), .out_valid(ov[0]), .busy(bz[0])
    );

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .reset(reset), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .grant(g[1]), .S0(s0[1]), .S1(s1[1]),
        .out_data(od[1]), .out_valid(ov[1]), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     n, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 = none), burst length, last winner.
    int mb     [2] = '{4, 1};
    int m_own  [2] = '{-1, -1};
    int m_len  [2] = '{0, 0};
    int m_last [2] = '{3, 3};
    int m_sel  [2] = '{0, 0};

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int d = 1; d <= 4; d++)
            if (r[(lst + d) % 4]) return (lst + d) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_own[k]  = -1;
                m_len[k]  = 0;
                m_last[k] = 3;
                m_sel[k]  = 0;
            end else if (m_own[k] < 0 || !req[m_own[k]]
                         || m_len[k] == mb[k]) begin
                if (req == 4'b0000) begin
                    m_own[k] = -1;
                    m_len[k] = 0;
                end else begin
                    m_own[k]  = pick(req, m_last[k]);
                    m_len[k]  = 1;
                    m_last[k] = m_own[k];
                    m_sel[k]  = m_own[k];
                end
            end else begin
                m_len[k]++;
            end
        end
    end

    function automatic logic [7:0] src(input int s);
        case (s)
            0: return da;
            1: return db;
            2: return dc;
            default: return dd;
        endcase
    endfunction

    // Compare process: checks both instances every cycle.
    always begin
        @(negedge clk);
        #2;
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] eg;
                logic       eb;
                eb = (m_own[k] >= 0);
                eg = eb ? 4'(1 << m_own[k]) : 4'b0000;
                chk($sformatf("m%0d_grant", k), 32'(g[k]), 32'(eg));
                chk($sformatf("m%0d_busy", k), 32'(bz[k]), 32'(eb));
                chk($sformatf("m%0d_sel", k), 32'({s1[k], s0[k]}),
                    32'(m_sel[k]));
                chk($sformatf("m%0d_data", k), 32'(od[k]),
                    32'(src(m_sel[k])));
                chk($sformatf("m%0d_valid", k), 32'(ov[k]),
                    32'(eb && req[m_sel[k]]));
                chk($sformatf("m%0d_onehot", k), 32'($onehot0(g[k])), 1);
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input logic rs);
        @(negedge clk);
        req   = r;
        reset = rs;
        da    = 8'($urandom);
        db    = 8'($urandom);
        dc    = 8'($urandom);
        dd    = 8'($urandom);
    endtask

    task automatic do_reset();
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
    endtask

    logic [3:0] r;

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        da = 0; db = 0; dc = 0; dd = 0;
        do_reset();
        checking = 1;

        // Reset state
        #2;
        chk("rst_grant", 32'(g[0]), 0);
        chk("rst_busy", 32'(bz[0]), 0);
        chk("rst_sel", 32'({s1[0], s0[0]}), 0);
        chk("rst_valid", 32'(ov[0]), 0);
        chk("rst_data", 32'(od[0]), 32'(da));

        // Sole requester A: latency 1, timeout re-grants A
        cyc(4'b0001, 1'b0); #2;
        chk("a_lat", 32'(g[0]), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0001, 1'b0); #2;
            chk("a_grant", 32'(g[0]), 1);
            chk("a_sel", 32'({s1[0], s0[0]}), 0);
            chk("a_valid", 32'(ov[0]), 1);
            chk("a_data", 32'(od[0]), 32'(da));
        end

        // Full load: A,B,C,D,A each for 4 cycles
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            cyc(4'b1111, 1'b0); #2;
            if (k == 1) chk("full_lat", 32'(g[0]), 0);
            else begin
                chk("full_grant", 32'(g[0]),
                    32'(1 << (((k - 2) / 4) % 4)));
                chk("full_sel", 32'({s1[0], s0[0]}),
                    32'(((k - 2) / 4) % 4));
            end
        end

        // A drops after 2 granted cycles, C follows
        do_reset();
        cyc(4'b0101, 1'b0);
        cyc(4'b0101, 1'b0); #2;
        chk("drop_g1", 32'(g[0]), 1);
        cyc(4'b0101, 1'b0); #2;
        chk("drop_g2", 32'(g[0]), 1);
        cyc(4'b0100, 1'b0); #2;
        chk("drop_g3", 32'(g[0]), 1);
        chk("drop_valid", 32'(ov[0]), 0);
        cyc(4'b0100, 1'b0);
        dc = 8'hC3; #2;
        chk("c_grant", 32'(g[0]), 4);
        chk("c_sel", 32'({s1[0], s0[0]}), 2);
        chk("c_data", 32'(od[0]), 32'h0C3);

        // D then idle, then A wins over D since last=3
        do_reset();
        cyc(4'b1000, 1'b0);
        cyc(4'b1000, 1'b0); #2;
        chk("d_grant", 32'(g[0]), 8);
        cyc(4'b0000, 1'b0); #2;
        chk("d_drop", 32'(g[0]), 8);
        chk("d_valid", 32'(ov[0]), 0);
        cyc(4'b0000, 1'b0); #2;
        chk("idle_grant", 32'(g[0]), 0);
        chk("idle_busy", 32'(bz[0]), 0);
        chk("idle_valid", 32'(ov[0]), 0);
        cyc(4'b1001, 1'b0); #2;
        chk("ad_lat", 32'(g[0]), 0);
        cyc(4'b1001, 1'b0); #2;
        chk("ad_grant", 32'(g[0]), 1);

        // Reset mid-burst while B holds
        do_reset();
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0); #2;
        chk("b_grant", 32'(g[0]), 2);
        cyc(4'b0010, 1'b1); #2;
        chk("b_hold", 32'(g[0]), 2);
        cyc(4'b0010, 1'b0); #2;
        chk("mid_rst_grant", 32'(g[0]), 0);
        chk("mid_rst_busy", 32'(bz[0]), 0);
        chk("mid_rst_sel", 32'({s1[0], s0[0]}), 0);
        cyc(4'b0010, 1'b0); #2;
        chk("b_regrant", 32'(g[0]), 2);

        // MAX_BURST=1: B and C alternate every cycle
        do_reset();
        cyc(4'b0110, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0110, 1'b0); #2;
            chk("mb1_alt", 32'(g[1]), (i % 2 == 0) ? 32'd2 : 32'd4);
        end

        // Random traffic, level requests with occasional reset
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            else if ($urandom_range(0, 5) == 0)
                r[$urandom_range(0, 3)] ^= 1'b1;
            cyc(r, ($urandom_range(0, 99) == 0));
        end
        cyc(4'b0000, 1'b0);
        @(negedge clk);
        #3;
        checking = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
